// File: rtl/pipeline_stage_register_pkg.sv
// Shared pipeline-boundary definitions: stage state encoding
// and per-boundary payload packing widths.
package pipe_pkg;

    localparam logic [1:0] PIPE_EMPTY = 2'd0;
    localparam logic [1:0] PIPE_FULL  = 2'd1;
    localparam logic [1:0] PIPE_SKID  = 2'd2;

    // pc + instruction
    localparam int IF_ID_DATA_WIDTH  = 64;
    localparam int IF_ID_CTRL_WIDTH  = 1;
    // pc + rs1 + rs2 + imm + rd
    localparam int ID_EX_DATA_WIDTH  = 133;
    localparam int ID_EX_CTRL_WIDTH  = 4;
    // pc + alu result + store data + rd
    localparam int EX_MEM_DATA_WIDTH = 101;
    localparam int EX_MEM_CTRL_WIDTH = 4;
    // result + rd
    localparam int MEM_WB_DATA_WIDTH = 37;
    localparam int MEM_WB_CTRL_WIDTH = 1;

endpackage

// File: rtl/pipeline_stage_register_if.sv
// Handshake bundle between an upstream stage, this register
// and the downstream stage.
interface pipeline_stage_register_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
);

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic [1:0]            occupancy;

    modport master (
        output flush, in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );

endinterface

// File: rtl/pipeline_stage_register_payload.sv
// Payload slot: async reset, load enable, synchronous clear.
module pipe_payload_reg #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_stage_register.sv
// Handshaked inter-stage register with optional skid slot,
// synchronous flush and bubble-gated control payload.
module pipeline_stage_register
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CTRL_WIDTH  = 4,
    parameter bit SKID_ENABLE = 1
) (
    input logic clk,
    input logic reset_n,
    pipeline_stage_register_if.slave stage
);

    localparam int PW = DATA_WIDTH + CTRL_WIDTH;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          accept;
    logic          emit;
    logic          main_load;
    logic          skid_load;
    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;

    assign stage.out_valid = (state != PIPE_EMPTY);
    assign accept = stage.in_valid & stage.in_ready;
    assign emit   = stage.out_valid & stage.out_ready;
    assign in_pl  = {stage.in_data, stage.in_ctrl};
    assign main_d = (state == PIPE_SKID) ? skid_q : in_pl;

    always_comb begin
        state_nx  = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        unique case (1'b1)
            state == PIPE_EMPTY: begin
                if (accept) begin
                    state_nx  = PIPE_FULL;
                    main_load = 1'b1;
                end
            end
            state == PIPE_FULL: begin
                if (emit && accept) begin
                    main_load = 1'b1;
                end else if (emit) begin
                    state_nx = PIPE_EMPTY;
                end else if (accept && SKID_ENABLE) begin
                    state_nx  = PIPE_SKID;
                    skid_load = 1'b1;
                end
            end
            state == PIPE_SKID: begin
                if (emit) begin
                    state_nx  = PIPE_FULL;
                    main_load = 1'b1;
                end
            end
            default: state_nx = PIPE_EMPTY;
        endcase
        // flush wins: incoming entry dropped, held entries killed
        if (stage.flush) begin
            state_nx = PIPE_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PIPE_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (main_load),
        .clear   (stage.flush),
        .d       (main_d),
        .q       (main_q)
    );

    generate
        if (SKID_ENABLE) begin : g_skid
            logic ready_q;

            pipe_payload_reg #(.W(PW)) u_skid (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (skid_load),
                .clear   (stage.flush),
                .d       (in_pl),
                .q       (skid_q)
            );

            // registered so in_ready never depends on out_ready
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_nx != PIPE_SKID);
                end
            end

            assign stage.in_ready = ready_q;
        end else begin : g_bare
            assign skid_q = '0;
            assign stage.in_ready = !stage.out_valid | stage.out_ready;
        end
    endgenerate

    assign stage.out_data  = main_q[PW-1:CTRL_WIDTH];
    assign stage.out_ctrl  = main_q[CTRL_WIDTH-1:0]
                           & {CTRL_WIDTH{stage.out_valid}};
    assign stage.occupancy = state;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: vector table, directed
// corner sequences and a queue-based random reference model.
module tb_pipeline_stage_register;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    pipeline_stage_register_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) bs ();
    pipeline_stage_register_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) bn ();

    pipeline_stage_register #(
        .DATA_WIDTH(32), .CTRL_WIDTH(4), .SKID_ENABLE(1)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .stage   (bs.slave)
    );

    pipeline_stage_register #(
        .DATA_WIDTH(32), .CTRL_WIDTH(4), .SKID_ENABLE(0)
    ) u_bare (
        .clk     (clk),
        .reset_n (reset_n),
        .stage   (bn.slave)
    );

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [3:0]  c;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ec;
        logic [1:0]  eo;
        logic        er;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          sel = 1'b0;
    logic [35:0] mq[$];
    bit          m_rdy = 1'b1;
    vec_t        tv[10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic [3:0] c, input logic r,
                         input logic f);
        bs.in_valid = v; bs.in_data = d; bs.in_ctrl = c;
        bs.out_ready = r; bs.flush = f;
        bn.in_valid = v; bn.in_data = d; bn.in_ctrl = c;
        bn.out_ready = r; bn.flush = f;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        m_rdy = 1'b1;
    endtask

    function automatic bit model_ready();
        if (sel) return (mq.size() == 0) || bs.out_ready;
        return m_rdy;
    endfunction

    task automatic check_model();
        bit          ev;
        logic [35:0] hd;
        ev = (mq.size() != 0);
        hd = ev ? mq[0] : 36'd0;
        chk("rnd_valid", sel ? bn.out_valid : bs.out_valid, ev);
        chk("rnd_occ", sel ? bn.occupancy : bs.occupancy, mq.size());
        chk("rnd_ctrl", sel ? bn.out_ctrl : bs.out_ctrl,
            ev ? hd[3:0] : 4'd0);
        if (ev) chk("rnd_data", sel ? bn.out_data : bs.out_data, hd[35:4]);
        chk("rnd_ready", sel ? bn.in_ready : bs.in_ready, model_ready());
    endtask

    // inputs already driven; checks current outputs, then advances one edge
    task automatic step_model();
        bit acc;
        bit emi;
        #1;
        check_model();
        acc = bs.in_valid && model_ready();
        emi = (mq.size() != 0) && bs.out_ready;
        @(posedge clk);
        if (emi) void'(mq.pop_front());
        if (bs.flush) mq.delete();
        else if (acc) mq.push_back({bs.in_data, bs.in_ctrl});
        m_rdy = (mq.size() < 2);
        #1;
    endtask

    initial begin
        tv[0] = '{1, 32'hA, 4'h1, 0, 0, 1, 32'hA, 4'h1, 2'd1, 1};
        tv[1] = '{1, 32'hB, 4'h2, 0, 0, 1, 32'hA, 4'h1, 2'd2, 0};
        tv[2] = '{1, 32'hC, 4'h3, 0, 0, 1, 32'hA, 4'h1, 2'd2, 0};
        tv[3] = '{0, 32'h0, 4'h0, 1, 0, 1, 32'hB, 4'h2, 2'd1, 1};
        tv[4] = '{0, 32'h0, 4'h0, 1, 0, 0, 32'h0, 4'h0, 2'd0, 1};
        tv[5] = '{1, 32'hA, 4'h5, 0, 0, 1, 32'hA, 4'h5, 2'd1, 1};
        tv[6] = '{1, 32'hB, 4'h6, 0, 0, 1, 32'hA, 4'h5, 2'd2, 0};
        tv[7] = '{1, 32'hC, 4'h7, 0, 1, 0, 32'h0, 4'h0, 2'd0, 1};
        tv[8] = '{0, 32'h0, 4'h0, 1, 0, 0, 32'h0, 4'h0, 2'd0, 1};
        tv[9] = '{1, 32'hD, 4'h9, 1, 1, 0, 32'h0, 4'h0, 2'd0, 1};

        do_reset();
        #1;
        chk("rst_valid", bs.out_valid, 0);
        chk("rst_data", bs.out_data, 0);
        chk("rst_ctrl", bs.out_ctrl, 0);
        chk("rst_occ", bs.occupancy, 0);
        chk("rst_ready", bs.in_ready, 1);
        chk("rst_ready_bare", bn.in_ready, 1);

        // single entry, one-cycle latency
        drive(1, 32'h0000_1234, 4'b1011, 1, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 0);
        chk("first_valid", bs.out_valid, 1);
        chk("first_data", bs.out_data, 32'h1234);
        chk("first_ctrl", bs.out_ctrl, 4'b1011);
        chk("first_occ", bs.occupancy, 1);
        @(posedge clk); #1;
        chk("first_drain", bs.out_valid, 0);

        // skid fill/drain and flush table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].iv, tv[i].d, tv[i].c, tv[i].ordy, tv[i].fl);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), bs.out_valid, tv[i].ev);
            chk($sformatf("vec%0d_ctrl", i), bs.out_ctrl, tv[i].ec);
            chk($sformatf("vec%0d_occ", i), bs.occupancy, tv[i].eo);
            chk($sformatf("vec%0d_ready", i), bs.in_ready, tv[i].er);
            if (tv[i].ev)
                chk($sformatf("vec%0d_data", i), bs.out_data, tv[i].ed);
        end

        // streaming 0..7 at full rate
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, i, 4'(i), 1, 0);
            @(posedge clk); #1;
            chk("stream_data", bs.out_data, i);
            chk("stream_valid", bs.out_valid, 1);
            chk("stream_ready", bs.in_ready, 1);
        end
        drive(0, 0, 0, 1, 0);
        @(posedge clk); #1;
        chk("stream_end", bs.out_valid, 0);

        // single-entry variant: in_ready follows out_ready combinationally
        do_reset();
        drive(1, 32'h55, 4'hF, 0, 0);
        @(posedge clk); #1;
        drive(1, 32'h66, 4'h1, 0, 0);
        #1;
        chk("bare_stall_ready", bn.in_ready, 0);
        drive(1, 32'h66, 4'h1, 1, 0);
        #1;
        chk("bare_go_ready", bn.in_ready, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        chk("bare_repl_data", bn.out_data, 32'h66);
        chk("bare_repl_ctrl", bn.out_ctrl, 4'h1);
        chk("bare_repl_occ", bn.occupancy, 1);

        // asynchronous reset between edges
        do_reset();
        drive(1, 32'h77, 4'hF, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        chk("arst_pre_ctrl", bs.out_ctrl, 4'hF);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", bs.out_valid, 0);
        chk("arst_ctrl", bs.out_ctrl, 0);
        chk("arst_occ", bs.occupancy, 0);
        chk("arst_data", bs.out_data, 0);

        // random traffic against the queue model, both variants
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            do_reset();
            #1;
            for (int n = 0; n < 400; n++) begin
                drive($urandom_range(0, 9) < 7, $urandom,
                      4'($urandom_range(0, 15)),
                      $urandom_range(0, 9) < 6,
                      $urandom_range(0, 19) == 0);
                step_model();
            end
            drive(0, 0, 0, 1, 0);
            step_model();
            step_model();
            step_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
